// File: rtl/bcd_pkg.sv
// Shared constants for the digit-serial BCD adder: digit width, BCD limits and FSM encodings.
package bcd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned BCD_MAX  = 9;
    localparam int unsigned BCD_CORR = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bcd_digit_cell.sv
// Combinational single-digit BCD adder: z/co = x + y + ci with decimal correction.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x_i,
    input  logic [DIGIT_W-1:0] y_i,
    input  logic               ci_i,
    output logic [DIGIT_W-1:0] z_o,
    output logic               co_o
);

    logic [DIGIT_W:0] sum_bin;
    logic [DIGIT_W:0] sum_corr;

    always_comb begin
        sum_bin  = {1'b0, x_i} + {1'b0, y_i} + {{DIGIT_W{1'b0}}, ci_i};
        sum_corr = sum_bin + (DIGIT_W + 1)'(BCD_CORR);
        if (sum_bin > (DIGIT_W + 1)'(BCD_MAX)) begin
            co_o = 1'b1;
            z_o  = sum_corr[DIGIT_W-1:0];
        end else begin
            co_o = 1'b0;
            z_o  = sum_bin[DIGIT_W-1:0];
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder, LSD first, one digit per clock.
// Optional input digit check enabled by defining BCD_INPUT_CHECK_EN.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [4*DIGITS-1:0]    a_i,
    input  logic [4*DIGITS-1:0]    b_i,
    input  logic                   cin_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*DIGITS-1:0]    sum_o,
    output logic                   cout_o,
    output logic                   err_o
);

    localparam int unsigned W    = DIGIT_W * DIGITS;
    localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [1:0]         state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               carry_q, carry_d, cout_q, cout_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DIGIT_W-1:0] cell_z;
    logic               cell_co;
    logic               accept;
    logic               last;

    bcd_digit_cell u_cell (
        .x_i  (a_q[DIGIT_W-1:0]),
        .y_i  (b_q[DIGIT_W-1:0]),
        .ci_i (carry_q),
        .z_o  (cell_z),
        .co_o (cell_co)
    );

    assign ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign accept  = start_i && ready_o;
    assign last    = (cnt_q == CntW'(DIGITS - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = ST_RUN;
            a_d     = a_i;
            b_d     = b_i;
            carry_d = cin_i;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_d                     = a_q >> DIGIT_W;
            b_d                     = b_q >> DIGIT_W;
            sum_d                   = sum_q >> DIGIT_W;
            sum_d[W-1 -: DIGIT_W]   = cell_z;
            carry_d                 = cell_co;
            cnt_d                   = cnt_q + 1'b1;
            if (last) begin
                state_d = ST_DONE;
                cout_d  = cell_co;
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_q, err_d;

    // Sticky across the whole operation; cleared only when a new operation is accepted.
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            err_d = err_q | (a_q[DIGIT_W-1:0] > DIGIT_W'(BCD_MAX))
                          | (b_q[DIGIT_W-1:0] > DIGIT_W'(BCD_MAX));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
